branch_resolve_ctrl: RTL and testbench

Sequencing controller for conditional branches in the ID stage. It owns the integer condition-code register (Z,N,C,V) and tracks whether a flag write is still in flight from a CC-setting instruction in EX. It stalls ID until the flags a branch depends on are valid, then resolves taken/not-taken and the delay-slot annul decision as a registered one-cycle pulse to the fetch unit.

---
 rtl/branch_resolve_ctrl.sv | 147 ++++++++++++++
 tb/tb_branch_resolve_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_ctrl.sv
// Branch resolve controller: owns the Z/N/C/V register, holds ID while a flag write is
// in flight, and hands fetch a registered taken/annul decision.
module branch_resolve_ctrl #(
  parameter int TIMEOUT = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       id_branch_valid,
  input  logic [3:0] id_cond,
  input  logic       id_annul,
  input  logic       ex_sets_cc,
  input  logic       cc_wr_en,
  input  logic [3:0] cc_wr_flags,
  input  logic       flush,
  output logic       stall_id,
  output logic       resolve_valid,
  output logic       branch_taken,
  output logic       annul_slot,
  output logic       cc_timeout,
  output logic [3:0] flags_q
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);

  typedef enum logic {IDLE, WAIT_CC} state_t;

  state_t        state;
  logic          cc_pending;
  logic [CW-1:0] wait_cnt;
  logic [3:0]    held_cond;
  logic          held_annul;

  logic       hazard;
  logic [3:0] eval_flags;
  logic       at_limit;
  logic       idle_taken;
  logic       wait_taken;
  logic       force_taken;

  // Codes 9..15 are the complements of 1..7; 8 is the complement of "never".
  function automatic logic cond_true(input logic [3:0] cond, input logic [3:0] f);
    logic z, n, c, v, base;
    z = f[3];
    n = f[2];
    c = f[1];
    v = f[0];
    case (cond[2:0])
      3'd0:    base = 1'b0;
      3'd1:    base = z;
      3'd2:    base = z | (n ^ v);
      3'd3:    base = n ^ v;
      3'd4:    base = c | z;
      3'd5:    base = c;
      3'd6:    base = n;
      default: base = v;
    endcase
    return base ^ cond[3];
  endfunction

  // Branch-always with annul squashes its slot even though it is taken.
  function automatic logic annul_of(input logic [3:0] cond, input logic annul,
                                    input logic taken);
    return annul & ((cond == 4'b1000) | ~taken);
  endfunction

  assign hazard      = ex_sets_cc | (cc_pending & ~cc_wr_en);
  assign eval_flags  = cc_wr_en ? cc_wr_flags : flags_q;
  assign at_limit    = (wait_cnt == CNT_MAX);
  assign idle_taken  = cond_true(id_cond, eval_flags);
  assign wait_taken  = cond_true(held_cond, eval_flags);
  assign force_taken = cond_true(held_cond, flags_q);

  // Gated by rst_n so an asserted reset releases ID without waiting for a clock.
  always_comb begin
    stall_id = 1'b0;
    if (rst_n && !flush) begin
      if (state == IDLE) stall_id = id_branch_valid & hazard;
      else               stall_id = hazard & ~at_limit;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      flags_q       <= 4'b0000;
      cc_pending    <= 1'b0;
      wait_cnt      <= '0;
      held_cond     <= 4'b0000;
      held_annul    <= 1'b0;
      resolve_valid <= 1'b0;
      branch_taken  <= 1'b0;
      annul_slot    <= 1'b0;
      cc_timeout    <= 1'b0;
    end else begin
      resolve_valid <= 1'b0;
      branch_taken  <= 1'b0;
      annul_slot    <= 1'b0;
      cc_timeout    <= 1'b0;

      if (cc_wr_en) flags_q <= cc_wr_flags;
      if (ex_sets_cc)    cc_pending <= 1'b1;
      else if (cc_wr_en) cc_pending <= 1'b0;

      if (flush) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (id_branch_valid) begin
              if (!hazard) begin
                resolve_valid <= 1'b1;
                branch_taken  <= idle_taken;
                annul_slot    <= annul_of(id_cond, id_annul, idle_taken);
              end else begin
                held_cond  <= id_cond;
                held_annul <= id_annul;
                wait_cnt   <= CW'(1);
                state      <= WAIT_CC;
              end
            end
          end
          WAIT_CC: begin
            if (!hazard) begin
              resolve_valid <= 1'b1;
              branch_taken  <= wait_taken;
              annul_slot    <= annul_of(held_cond, held_annul, wait_taken);
              state         <= IDLE;
            end else if (at_limit) begin
              // Give up on the in-flight write and decide on the architectural flags.
              resolve_valid <= 1'b1;
              branch_taken  <= force_taken;
              annul_slot    <= annul_of(held_cond, held_annul, force_taken);
              cc_timeout    <= 1'b1;
              cc_pending    <= 1'b0;
              state         <= IDLE;
            end else begin
              wait_cnt <= wait_cnt + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Randomized + directed bench for branch_resolve_ctrl: a per-cycle reference model
// predicts stalls and pushes expected decisions; a negedge monitor pops and compares.
module tb_branch_resolve_ctrl;
  localparam int TIMEOUT = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       id_branch_valid = 1'b0;
  logic [3:0] id_cond = 4'b0;
  logic       id_annul = 1'b0;
  logic       ex_sets_cc = 1'b0;
  logic       cc_wr_en = 1'b0;
  logic [3:0] cc_wr_flags = 4'b0;
  logic       flush = 1'b0;
  logic       stall_id, resolve_valid, branch_taken, annul_slot, cc_timeout;
  logic [3:0] flags_q;

  always #5 clk = ~clk;

  branch_resolve_ctrl #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .id_branch_valid(id_branch_valid), .id_cond(id_cond),
    .id_annul(id_annul), .ex_sets_cc(ex_sets_cc), .cc_wr_en(cc_wr_en),
    .cc_wr_flags(cc_wr_flags), .flush(flush), .stall_id(stall_id),
    .resolve_valid(resolve_valid), .branch_taken(branch_taken), .annul_slot(annul_slot),
    .cc_timeout(cc_timeout), .flags_q(flags_q)
  );

  typedef struct { int cyc; bit taken; bit annul; bit tmo; } exp_t;
  exp_t sbq[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int n_stall;

  // Reference model: architectural flags, an "update in flight" marker, and the
  // branch currently parked in ID together with how many cycles it has stalled.
  logic [3:0] m_flags;
  bit         m_inflight;
  bit         m_parked;
  int         m_stalls;
  logic [3:0] m_cond;
  bit         m_annul;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic bit ref_taken(logic [3:0] cond, logic [3:0] f);
    bit z = f[3], n = f[2], c = f[1], v = f[0];
    bit r;
    case (cond)
      4'h0: r = 0;              4'h8: r = 1;
      4'h1: r = z;              4'h9: r = !z;
      4'h2: r = z | (n ^ v);    4'hA: r = !(z | (n ^ v));
      4'h3: r = n ^ v;          4'hB: r = !(n ^ v);
      4'h4: r = c | z;          4'hC: r = !(c | z);
      4'h5: r = c;              4'hD: r = !c;
      4'h6: r = n;              4'hE: r = !n;
      default: r = v;
    endcase
    if (cond == 4'hF) r = !v;
    return r;
  endfunction

  function automatic bit ref_annul(logic [3:0] cond, bit annul, bit taken);
    if (!annul) return 0;
    if (cond == 4'b1000) return 1;
    return !taken;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic pushExpect(input logic [3:0] cond, input bit annul, input logic [3:0] f,
                            input bit tmo);
    bit t;
    t = ref_taken(cond, f);
    sbq.push_back('{cyc + 1, t, ref_annul(cond, annul, t), tmo});
  endtask

  task automatic modelReset();
    m_flags = 4'b0; m_inflight = 0; m_parked = 0; m_stalls = 0; m_cond = 4'b0; m_annul = 0;
    sbq.delete();
  endtask

  task automatic applyStimulus(input bit br, input logic [3:0] cond, input bit annul,
                               input bit ex, input bit wr, input logic [3:0] fl, input bit fsh);
    bit hz, exp_stall, forced;
    logic [3:0] f;
    @(negedge clk);
    id_branch_valid = br; id_cond = cond; id_annul = annul;
    ex_sets_cc = ex; cc_wr_en = wr; cc_wr_flags = fl; flush = fsh;
    #1;
    hz = ex | (m_inflight & !wr);
    f = wr ? fl : m_flags;
    exp_stall = 0;
    forced = 0;
    if (fsh) begin
      m_parked = 0;
    end else if (!m_parked) begin
      if (br && !hz) pushExpect(cond, annul, f, 0);
      else if (br) begin
        exp_stall = 1; m_parked = 1; m_stalls = 1; m_cond = cond; m_annul = annul;
      end
    end else if (!hz) begin
      pushExpect(m_cond, m_annul, f, 0);
      m_parked = 0;
    end else if (m_stalls == TIMEOUT) begin
      pushExpect(m_cond, m_annul, m_flags, 1);
      m_parked = 0;
      forced = 1;
    end else begin
      exp_stall = 1;
      m_stalls++;
    end
    checkOutput("stall_id", stall_id, exp_stall);
    checkOutput("flags_q", flags_q, m_flags);
    if (stall_id) n_stall++;
    if (ex) m_inflight = 1;
    else if (wr) m_inflight = 0;
    if (forced) m_inflight = 0;
    if (wr) m_flags = fl;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (resolve_valid) begin
        if (sbq.size() == 0) begin
          checkOutput("unexpected_resolve", 1, 0);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          checkOutput("resolve_cycle", cyc, e.cyc);
          checkOutput("branch_taken", branch_taken, e.taken);
          checkOutput("annul_slot", annul_slot, e.annul);
          checkOutput("cc_timeout", cc_timeout, e.tmo);
        end
      end else begin
        checkOutput("quiet_outputs", {branch_taken, annul_slot, cc_timeout}, 0);
      end
    end
  end

  initial begin
    modelReset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_flags_q", flags_q, 0);
    checkOutput("reset_outputs", {stall_id, resolve_valid, branch_taken, annul_slot, cc_timeout}, 0);
    rst_n = 1'b1;

    $display("[TB] basic Z branch");
    applyStimulus(0, 4'h0, 0, 0, 1, 4'b1000, 0);
    applyStimulus(1, 4'h1, 0, 0, 0, 4'b0000, 0);

    $display("[TB] hazard with bypass");
    applyStimulus(0, 4'h0, 0, 0, 1, 4'b0100, 0);
    applyStimulus(1, 4'hB, 0, 1, 0, 4'b0000, 0);
    applyStimulus(1, 4'hB, 0, 0, 1, 4'b0000, 0);

    $display("[TB] annul cases");
    applyStimulus(1, 4'h8, 1, 0, 0, 4'b0000, 0);
    applyStimulus(1, 4'h1, 1, 0, 0, 4'b0000, 0);
    applyStimulus(1, 4'h0, 0, 0, 0, 4'b0000, 0);

    $display("[TB] timeout");
    applyStimulus(0, 4'h0, 0, 0, 1, 4'b0010, 0);
    n_stall = 0;
    applyStimulus(1, 4'h5, 1, 1, 0, 4'b0000, 0);
    for (int i = 0; i < TIMEOUT; i++) applyStimulus(1, 4'h5, 1, 0, 0, 4'b0000, 0);
    checkOutput("timeout_stall_len", n_stall, TIMEOUT);
    applyStimulus(1, 4'hD, 0, 0, 0, 4'b0000, 0);

    $display("[TB] flush while waiting");
    applyStimulus(1, 4'h1, 0, 1, 0, 4'b0000, 0);
    applyStimulus(1, 4'h1, 0, 0, 0, 4'b0000, 0);
    applyStimulus(1, 4'h1, 0, 0, 0, 4'b0000, 1);
    applyStimulus(0, 4'h0, 0, 0, 1, 4'b1111, 0);

    $display("[TB] async reset while waiting");
    applyStimulus(1, 4'h3, 0, 1, 0, 4'b0000, 0);
    applyStimulus(1, 4'h3, 0, 0, 0, 4'b0000, 0);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_stall_id", stall_id, 0);
    checkOutput("midrst_flags_q", flags_q, 0);
    checkOutput("midrst_outputs", {resolve_valid, branch_taken, annul_slot, cc_timeout}, 0);
    modelReset();
    id_branch_valid = 0; ex_sets_cc = 0; cc_wr_en = 0;
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] condition sweep");
    for (int c = 0; c < 16; c++)
      for (int fv = 0; fv < 16; fv++)
        for (int a = 0; a < 2; a++)
          applyStimulus(1, 4'(c), a[0], 0, 1, 4'(fv), 0);

    $display("[TB] random traffic");
    for (int i = 0; i < 1500; i++)
      applyStimulus($urandom_range(0, 1) == 1, 4'($urandom_range(0, 15)),
                    $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
                    $urandom_range(0, 2) == 0, 4'($urandom_range(0, 15)),
                    $urandom_range(0, 15) == 0);

    applyStimulus(0, 4'h0, 0, 0, 1, 4'b0000, 0);
    applyStimulus(0, 4'h0, 0, 0, 0, 4'b0000, 0);
    @(negedge clk);
    #2;
    checkOutput("scoreboard_left", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
